// File: rtl/fazyrv_ram_wb_if.sv
// fazyrv_ram_wb_if: Wishbone-classic bus between the SoC interconnect and the RAM responder
interface fazyrv_ram_wb_if #(
    parameter int REGW = 32,
    parameter int ADRW = 10
);
    logic              cyc_i;
    logic              stb_i;
    logic              we_i;
    logic [REGW/8-1:0] be_i;
    logic [ADRW-1:0]   adr_i;
    logic [REGW-1:0]   dat_i;
    logic [REGW-1:0]   dat_o;
    logic              ack_o;

    modport master (output cyc_i, stb_i, we_i, be_i, adr_i, dat_i, input dat_o, ack_o);
    modport slave  (input cyc_i, stb_i, we_i, be_i, adr_i, dat_i, output dat_o, ack_o);
endinterface

// File: rtl/fazyrv_ram_wb.sv
// fazyrv_ram_wb: Wishbone responder for single-port SoC RAM; partial writes use read-modify-write
module fazyrv_ram_wb #(
    parameter int REGW  = 32,
    parameter int ADRW  = 10,
    parameter int DEPTH = 1024
) (
    input  logic             clk_i,
    input  logic             rst_i,
    fazyrv_ram_wb_if.slave   wb,
    output logic             ram_we_o,
    output logic [ADRW-1:0]  ram_waddr_o,
    output logic [ADRW-1:0]  ram_raddr_o,
    output logic [REGW-1:0]  ram_wdata_o,
    input  logic [REGW-1:0]  ram_rdata_i
);
    localparam int BW = REGW / 8;
    localparam logic [ADRW:0] LIM = (ADRW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, RD, MRG, ACK} state_t;

    state_t          r_state, w_state;
    logic            r_ack;
    logic [REGW-1:0] r_dat, w_dat, r_wdat, w_mrg;
    logic [ADRW-1:0] r_adr;
    logic [BW-1:0]   r_be;
    logic            w_req, w_oor, w_idle;

    assign w_req       = wb.cyc_i & wb.stb_i;
    assign w_oor       = {1'b0, wb.adr_i} >= LIM;
    assign w_idle      = r_state == IDLE;
    assign wb.ack_o    = r_ack;
    assign wb.dat_o    = r_dat;
    assign ram_raddr_o = w_idle ? wb.adr_i : r_adr;
    assign ram_waddr_o = ram_raddr_o;
    assign ram_wdata_o = w_idle ? wb.dat_i : w_mrg;

    always_comb begin
        w_mrg = ram_rdata_i;
        for (int k = 0; k < BW; k++)
            if (r_be[k]) w_mrg[8*k +: 8] = r_wdat[8*k +: 8];
    end

    always_comb begin
        w_state  = IDLE;
        w_dat    = r_dat;
        ram_we_o = 1'b0;
        case (r_state)
            IDLE: if (w_req) begin
                if (w_oor) begin
                    w_state = ACK;
                    w_dat   = wb.we_i ? r_dat : '0;
                end else if (!wb.we_i) begin
                    w_state = RD;
                end else if (&wb.be_i || ~|wb.be_i) begin
                    w_state  = ACK;
                    ram_we_o = &wb.be_i;
                end else begin
                    w_state = MRG;
                end
            end
            RD: if (wb.cyc_i) begin
                w_state = ACK;
                w_dat   = ram_rdata_i;
            end
            MRG: if (wb.cyc_i) begin
                w_state  = ACK;
                ram_we_o = 1'b1;
            end
            default: w_state = IDLE;
        endcase
        // A write must never reach the RAM while reset is asserted
        if (rst_i) ram_we_o = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_ack   <= 1'b0;
            r_dat   <= '0;
            r_adr   <= '0;
            r_wdat  <= '0;
            r_be    <= '0;
        end else begin
            r_state <= w_state;
            r_ack   <= w_state == ACK;
            r_dat   <= w_dat;
            if (w_idle && w_req) begin
                r_adr  <= wb.adr_i;
                r_wdat <= wb.dat_i;
                r_be   <= wb.be_i;
            end
        end
    end
endmodule

// File: tb/tb_fazyrv_ram_wb.sv
// tb_fazyrv_ram_wb: randomized self-checking bench for fazyrv_ram_wb against a word/byte memory model
module tb_fazyrv_ram_wb;
    localparam int REGW = 32, ADRW = 5, DEPTH = 16;

    logic              clk = 1'b0, rst = 1'b1;
    logic              ram_we;
    logic [ADRW-1:0]   ram_waddr, ram_raddr;
    logic [REGW-1:0]   ram_wdata, ram_rdata;
    logic [REGW-1:0]   ram [32];
    logic [REGW-1:0]   ref_mem [DEPTH];
    int n_tests = 0, n_fail = 0, edge_n = 0, we_cnt = 0, we_edge = -1, we_rst = 0;

    fazyrv_ram_wb_if #(.REGW(REGW), .ADRW(ADRW)) wb();

    fazyrv_ram_wb #(.REGW(REGW), .ADRW(ADRW), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst), .wb(wb), .ram_we_o(ram_we), .ram_waddr_o(ram_waddr),
        .ram_raddr_o(ram_raddr), .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM plus write activity monitor
    always @(posedge clk) begin
        if (ram_we) begin
            we_cnt++;
            we_edge = edge_n;
            if (rst) we_rst++;
            ram[ram_waddr] <= ram_wdata;
        end
        ram_rdata <= ram[ram_raddr];
        edge_n++;
    end

    task automatic wb_op(input logic we, input logic [3:0] be, input logic [ADRW-1:0] adr,
                         input logic [31:0] dat, output int lat, output logic [31:0] rd, output int t0);
        @(negedge clk);
        wb.cyc_i = 1'b1; wb.stb_i = 1'b1; wb.we_i = we; wb.be_i = be; wb.adr_i = adr; wb.dat_i = dat;
        t0 = edge_n; lat = -1; rd = 'x;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (wb.ack_o) begin
                lat = i;
                rd = wb.dat_o;
                break;
            end
        end
        wb.cyc_i = 1'b0; wb.stb_i = 1'b0; wb.we_i = 1'b0;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_tests++;
            if (wb.ack_o !== 1'b0 || wb.dat_o !== 32'h0 || ram_we !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_state: ack=%b dat=%h we=%b want 0/0/0", wb.ack_o, wb.dat_o, ram_we);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 32; i++) ram[i] = $urandom;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = ram[i];
    endtask

    task automatic test_full_rw;
        int lat, t0, c; logic [31:0] rd;
        wb_op(1'b1, 4'hF, 5, 32'hDEADBEEF, lat, rd, t0);
        ref_mem[5] = 32'hDEADBEEF;
        n_tests++; if (lat !== 1) begin n_fail++; $display("FAIL full_wr_lat: got %0d want 1", lat); end
        n_tests++; if (we_edge !== t0) begin n_fail++; $display("FAIL full_wr_cycle: got %0d want %0d", we_edge, t0); end
        n_tests++; if (ram[5] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL full_wr_mem: got %h want deadbeef", ram[5]); end
        wb_op(1'b0, 4'h0, 5, 32'h0, lat, rd, t0);
        n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL rd_lat: got %0d want 2", lat); end
        n_tests++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data: got %h want deadbeef", rd); end
        wb_op(1'b1, 4'hF, 6, 32'h12345678, lat, rd, t0);
        ref_mem[6] = 32'h12345678;
        n_tests++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL dat_hold: got %h want deadbeef", rd); end
        c = we_cnt;
        wb_op(1'b1, 4'h0, 6, 32'hFFFFFFFF, lat, rd, t0);
        n_tests++; if (lat !== 1) begin n_fail++; $display("FAIL be0_lat: got %0d want 1", lat); end
        n_tests++; if (we_cnt !== c || ram[6] !== 32'h12345678) begin
            n_fail++; $display("FAIL be0_nowrite: writes=%0d mem=%h want 0/12345678", we_cnt - c, ram[6]);
        end
    endtask

    task automatic test_partial;
        int lat, t0; logic [31:0] rd;
        @(negedge clk);
        ram[7] = 32'h11223344; ref_mem[7] = 32'h11BB33DD;
        wb_op(1'b1, 4'h5, 7, 32'hAABBCCDD, lat, rd, t0);
        n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL part_lat: got %0d want 2", lat); end
        n_tests++; if (we_edge !== t0 + 1) begin n_fail++; $display("FAIL part_cycle: got %0d want %0d", we_edge, t0 + 1); end
        n_tests++; if (ram[7] !== 32'h11BB33DD) begin n_fail++; $display("FAIL part_mem: got %h want 11bb33dd", ram[7]); end
        wb_op(1'b0, 4'h0, 7, 32'h0, lat, rd, t0);
        n_tests++; if (rd !== 32'h11BB33DD) begin n_fail++; $display("FAIL part_rd: got %h want 11bb33dd", rd); end
    endtask

    task automatic test_oor;
        int lat, t0, c; logic [31:0] rd;
        wb_op(1'b0, 4'h0, 5, 32'h0, lat, rd, t0);
        c = we_cnt;
        wb_op(1'b0, 4'h0, 20, 32'h0, lat, rd, t0);
        n_tests++; if (lat !== 1) begin n_fail++; $display("FAIL oor_rd_lat: got %0d want 1", lat); end
        n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL oor_rd_data: got %h want 0", rd); end
        wb_op(1'b1, 4'hF, 20, 32'hCAFEF00D, lat, rd, t0);
        n_tests++; if (lat !== 1) begin n_fail++; $display("FAIL oor_wr_lat: got %0d want 1", lat); end
        n_tests++; if (we_cnt !== c) begin n_fail++; $display("FAIL oor_nowrite: writes=%0d want 0", we_cnt - c); end
    endtask

    task automatic test_abort;
        int lat, t0, c, acks; logic [31:0] rd;
        c = we_cnt; acks = 0;
        @(negedge clk);
        wb.cyc_i = 1'b1; wb.stb_i = 1'b1; wb.we_i = 1'b1; wb.be_i = 4'h3; wb.adr_i = 9; wb.dat_i = $urandom;
        @(negedge clk);
        wb.cyc_i = 1'b0; wb.stb_i = 1'b0; wb.we_i = 1'b0;
        for (int i = 0; i < 3; i++) begin @(negedge clk); acks += int'(wb.ack_o); end
        wb.cyc_i = 1'b1; wb.stb_i = 1'b1; wb.adr_i = 9;
        @(negedge clk);
        wb.cyc_i = 1'b0; wb.stb_i = 1'b0;
        for (int i = 0; i < 3; i++) begin @(negedge clk); acks += int'(wb.ack_o); end
        n_tests++; if (acks !== 0) begin n_fail++; $display("FAIL abort_ack: got %0d acks want 0", acks); end
        n_tests++; if (we_cnt !== c || ram[9] !== ref_mem[9]) begin
            n_fail++; $display("FAIL abort_nowrite: writes=%0d mem=%h want 0/%h", we_cnt - c, ram[9], ref_mem[9]);
        end
        wb_op(1'b0, 4'h0, 9, 32'h0, lat, rd, t0);
        n_tests++; if (lat !== 2 || rd !== ref_mem[9]) begin
            n_fail++; $display("FAIL abort_recover: lat=%0d dat=%h want 2/%h", lat, rd, ref_mem[9]);
        end
    endtask

    task automatic test_reset_mid;
        int lat, t0, c, acks; logic [31:0] rd;
        c = we_cnt; acks = 0;
        @(negedge clk);
        wb.cyc_i = 1'b1; wb.stb_i = 1'b1; wb.we_i = 1'b1; wb.be_i = 4'h2; wb.adr_i = 10; wb.dat_i = $urandom;
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_tests++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL rst_mid_we: got %b want 0", ram_we); end
        @(negedge clk);
        rst = 1'b0; wb.cyc_i = 1'b0; wb.stb_i = 1'b0; wb.we_i = 1'b0;
        acks += int'(wb.ack_o);
        @(negedge clk);
        acks += int'(wb.ack_o);
        n_tests++; if (acks !== 0) begin n_fail++; $display("FAIL rst_mid_ack: got %0d acks want 0", acks); end
        n_tests++; if (we_cnt !== c || we_rst !== 0 || ram[10] !== ref_mem[10]) begin
            n_fail++; $display("FAIL rst_mid_nowrite: writes=%0d in_rst=%0d mem=%h want 0/0/%h", we_cnt - c, we_rst, ram[10], ref_mem[10]);
        end
        wb_op(1'b1, 4'hF, 10, 32'h0BADCAFE, lat, rd, t0);
        ref_mem[10] = 32'h0BADCAFE;
        wb_op(1'b0, 4'h0, 10, 32'h0, lat, rd, t0);
        n_tests++; if (lat !== 2 || rd !== 32'h0BADCAFE) begin
            n_fail++; $display("FAIL rst_mid_recover: lat=%0d dat=%h want 2/0badcafe", lat, rd);
        end
    endtask

    task automatic test_back_to_back;
        int c; logic [3:0] pat; logic [31:0] d;
        c = we_cnt; d = $urandom;
        @(negedge clk);
        wb.cyc_i = 1'b1; wb.stb_i = 1'b1; wb.we_i = 1'b1; wb.be_i = 4'hF; wb.adr_i = 11; wb.dat_i = d;
        for (int i = 0; i < 4; i++) begin @(negedge clk); pat[i] = wb.ack_o; end
        wb.cyc_i = 1'b0; wb.stb_i = 1'b0; wb.we_i = 1'b0;
        ref_mem[11] = d;
        n_tests++; if (pat !== 4'b0101) begin n_fail++; $display("FAIL b2b_acks: got %b want 0101", pat); end
        n_tests++; if (we_cnt !== c + 2) begin n_fail++; $display("FAIL b2b_writes: got %0d want 2", we_cnt - c); end
    endtask

    task automatic test_random;
        int lat, t0, exp_lat; logic [31:0] rd, last, d; logic we; logic [3:0] be; logic [ADRW-1:0] adr;
        wb_op(1'b0, 4'h0, 0, 32'h0, lat, rd, t0);
        last = ref_mem[0];
        n_tests++; if (rd !== last) begin n_fail++; $display("FAIL rnd_first: got %h want %h", rd, last); end
        for (int n = 0; n < 80; n++) begin
            we = 1'($urandom_range(0, 1));
            adr = ADRW'($urandom_range(0, 19));
            be = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15));
            d = $urandom;
            exp_lat = (adr >= DEPTH || (we && (be == 4'hF || be == 4'h0))) ? 1 : 2;
            wb_op(we, be, adr, d, lat, rd, t0);
            if (!we) last = (adr >= DEPTH) ? 32'h0 : ref_mem[adr];
            else if (adr < DEPTH)
                for (int k = 0; k < 4; k++) if (be[k]) ref_mem[adr][8*k +: 8] = d[8*k +: 8];
            n_tests++;
            if (lat !== exp_lat || rd !== last) begin
                n_fail++;
                $display("FAIL rnd_op%0d we=%b be=%h adr=%0d: lat=%0d dat=%h want %0d/%h", n, we, be, adr, lat, rd, exp_lat, last);
            end
        end
        @(negedge clk);
        for (int i = 0; i < DEPTH; i++) begin
            n_tests++;
            if (ram[i] !== ref_mem[i]) begin n_fail++; $display("FAIL rnd_mem[%0d]: got %h want %h", i, ram[i], ref_mem[i]); end
        end
    endtask

    initial begin
        wb.cyc_i = 1'b0; wb.stb_i = 1'b0; wb.we_i = 1'b0; wb.be_i = '0; wb.adr_i = '0; wb.dat_i = '0;
        test_reset;
        test_full_rw;
        test_partial;
        test_oor;
        test_abort;
        test_reset_mid;
        test_back_to_back;
        test_random;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule

// File: doc/fazyrv_ram_wb.md
# fazyrv_ram_wb

Wishbone-classic responder that sits between the FazyRV SoC bus and the single-port SoC RAM, acting as the initiator on the RAM's we/waddr/raddr/wdata/rdata port. It turns bus reads into RAM reads with fixed latency, full-word writes into single RAM writes, and partial byte-enable writes into a read-modify-write sequence, because the RAM port only writes whole words. Addresses at or beyond DEPTH are acknowledged harmlessly.

## Interface
- REGW, 32, data width; multiple of 8
- ADRW, 10, word-address width on bus and RAM
- DEPTH, 1024, implemented words; must be ≤ 2^ADRW
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset; one clock; reset is synchronous and active-high
- wb_cyc_i  in  1  bus cycle valid
- wb_stb_i  in  1  strobe; request = cyc & stb
- wb_we_i  in  1  1 = write
- wb_be_i  in  REGW/8  byte enables (writes only)
- wb_adr_i  in  ADRW  word address
- wb_dat_i  in  REGW  write data
- wb_dat_o  out  REGW  read data, registered
- wb_ack_o  out  1  acknowledge, registered one-cycle pulse
- ram_we_o  out  1  RAM write enable
- ram_waddr_o  out  ADRW  RAM write address
- ram_raddr_o  out  ADRW  RAM read address
- ram_wdata_o  out  REGW  RAM write data
- ram_rdata_i  in  REGW  RAM read data, valid the cycle after raddr is presented

## Operation
- States: IDLE, RD (waiting for RAM data), MRG (merge and write back), ACK.
- IDLE, request, address ≥ DEPTH: no RAM access; ACK next; wb_dat_o ← 0 on reads.
- IDLE, read: ram_raddr_o = wb_adr_i combinationally; latch address; → RD.
- RD: if cyc_i low → IDLE, no ack (abort). Else wb_dat_o ← ram_rdata_i, wb_ack_o ← 1, → ACK.
- IDLE, write, be all ones: ram_we_o = 1, ram_waddr_o = wb_adr_i, ram_wdata_o = wb_dat_i in the same cycle; wb_ack_o ← 1; → ACK.
- IDLE, write, be == 0: no RAM write; wb_ack_o ← 1; → ACK.
- IDLE, write, partial be: present read of wb_adr_i; latch address, data, be; → MRG.
- MRG: if cyc_i low → IDLE, no RAM write. Else ram_we_o = 1 with per-byte merge: byte k = be[k] ? latched wdata byte k : ram_rdata_i byte k; wb_ack_o ← 1; → ACK.
- ACK: wb_ack_o high for this cycle only; → IDLE. A request present in ACK is ignored; if still present in IDLE next cycle it is taken as a new transaction.
- Outside IDLE, ram_raddr_o and ram_waddr_o carry the latched address. In IDLE without a request, they follow wb_adr_i.
- ram_we_o is combinational and gated by !rst_i.
- wb_dat_o holds its value until the next read completion. Writes do not change it.

## Timing
- Request sampled in cycle T (state IDLE).
- Read: RAM data at T+1; wb_ack_o and wb_dat_o valid at T+2.
- Full write and be == 0 write: RAM write in T; wb_ack_o at T+1.
- Partial write: RAM read in T; merged write in T+1; wb_ack_o at T+2.
- Out-of-range access: wb_ack_o at T+1.
- Maximum throughput: one transaction per 2 cycles (full writes) or per 3 cycles (reads, partial writes).
- Reset values: state IDLE, wb_ack_o 0, wb_dat_o 0, ram_we_o 0, latched address/data/be 0.
- Reset mid-transaction: returns to IDLE on the next edge; no ack; no RAM write occurs in any cycle where rst_i is high.
- A cyc_i drop in the ACK cycle does not cancel the ack; the write has already been committed.

## Test plan
- Reset then idle: rst_i high for 2 cycles → wb_ack_o = 0, wb_dat_o = 0, ram_we_o = 0 throughout.
- Full write then read: write 0xDEADBEEF to addr 5 with be = 0xF (ack at T+1), then read addr 5 → wb_ack_o at T+2, wb_dat_o = 0xDEADBEEF.
- Partial write: word 7 = 0x11223344; write 0xAABBCCDD to addr 7 with be = 0x5 → RAM written at T+1 with 0x11BB33DD; a read returns 0x11BB33DD.
- Out of range: DEPTH = 16; read addr 20 → ack at T+1 with wb_dat_o = 0, no RAM access. Write to addr 20 → ack, ram_we_o stays 0.
- Abort: partial write with cyc_i dropped at T+1 → no ram_we_o, no ack, state back to IDLE. Same for a read dropped in RD.
- Reset mid-operation: assert rst_i in the MRG cycle → ram_we_o = 0 that cycle, no ack, next request is serviced normally.
